pc_sequencer: RTL

Program-counter sequencer for the single-cycle core, directly downstream of the conditional-branch evaluator. It consumes that evaluator's 1-bit taken decision together with the decoder's unconditional-jump, link and halt controls, and produces the next fetch address. It also produces the link-register write for `bl`, a redirect pulse, a halt/resume state machine and a saturating retired-instruction counter.

---
 rtl/pc_sequencer.sv | 64 ++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next fetch address, link write, redirect pulse, halt/resume FSM and retired-instruction counter
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        cond_taken,
  input  logic [1:0]  uncond_type,
  input  logic [31:0] offset,
  input  logic [31:0] reg_target,
  input  logic        link_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        halted,
  output logic [31:0] instr_count
);
  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [1:0]  state, state_nxt;
  logic        acc, rel, jmp;
  logic [31:0] seq, nxt;
  always_comb begin
    acc       = state == RUN && instr_valid && !stall;
    rel       = uncond_type == 2'b01 || (uncond_type != 2'b10 && cond_taken);
    jmp       = !halt_req && (uncond_type == 2'b10 || rel);
    seq       = pc + PC_STEP;
    nxt       = halt_req ? seq : uncond_type == 2'b10 ? reg_target : rel ? pc + offset : seq;
    state_nxt = state == BOOT ? RUN :
                state == RUN ? (acc && halt_req ? HALTED : RUN) :
                state == HALTED ? (resume ? RUN : HALTED) : BOOT;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pc_valid    <= 1'b0;
      redirect    <= 1'b0;
      link_we     <= 1'b0;
      link_data   <= '0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= state_nxt;
      pc_valid <= state_nxt == RUN;
      halted   <= state_nxt == HALTED;
      redirect <= acc && jmp;
      link_we  <= acc && link_req && !halt_req;
      if (acc) begin
        pc          <= nxt;
        instr_count <= instr_count + {31'd0, instr_count != 32'hFFFF_FFFF};
        if (link_req && !halt_req) link_data <= seq;
      end
    end
  end
endmodule
